dm_store_unit: RTL
==================

DM_STORE_UNIT -- requirements
Module: dm_store_unit

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL: start  input  1  request strobe; sampled only in IDLE.
REQ-004 SHALL: op  input  6  instr[31:26]; OP_SB=6'b101000, OP_SH=6'b101001, OP_SW=6'b101011.
REQ-005 SHALL: addr  input  32  byte address (ALU result).
REQ-006 SHALL: wdata  input  32  store data (rt value).
REQ-007 SHALL: busy  output  1  high in every state except IDLE.
REQ-008 SHALL: done  output  1  one-cycle completion pulse.
REQ-009 SHALL: err  output  1  valid only with done; 1 = request rejected, no memory write.
REQ-010 SHALL: mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-011 SHALL: mem_rd / mem_wr  output  1 each  word read / word write request; never both high.
REQ-012 SHALL: mem_wdata  output  32  word to write; mem_rdata  input  32  read word, valid when mem_ready.
REQ-013 SHALL: mem_ready  input  1  memory accepts the current mem_rd/mem_wr this cycle.

Function
REQ-014 SHALL: FSM states IDLE, READ, MERGE, WRITE, DONE.
REQ-015 SHALL: IDLE with start=1 latches op, addr and wdata; start while busy=1 is ignored.
REQ-016 SHALL: accepted SW goes IDLE->WRITE; accepted SB/SH goes IDLE->READ (read-modify-write, memory is word-only).
REQ-017 SHALL: READ holds mem_rd=1 until mem_ready=1, captures mem_rdata that cycle, then goes to MERGE.
REQ-018 SHALL: MERGE lasts one cycle and forms the merged word; SB replaces byte lane addr[1:0] (00->[7:0], 01->[15:8], 10->[23:16], 11->[31:24]) with wdata[7:0].
REQ-019 SHALL: SH replaces [15:0] when addr[1]=0, or [31:16] when addr[1]=1, with wdata[15:0]; untouched bits keep the read value.
REQ-020 SHALL: WRITE holds mem_wr=1 and stable mem_addr/mem_wdata until mem_ready=1, then goes to DONE.
REQ-021 SHALL: DONE asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-022 SHALL: an op other than SB/SH/SW goes IDLE->DONE with err=1 and no memory access.
REQ-023 SHALL: with zero-wait memory, latency start->done is 2 cycles for SW and 4 cycles for SB/SH.
REQ-024 SHALL: mem_rd, mem_wr, done, err and busy are decoded from registered state and latched data only (no start->output combinational path).

Reset
REQ-025 SHALL: rst forces IDLE immediately; busy=0, done=0, err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, latched registers=0.
REQ-026 SHALL: rst mid-operation abandons the operation with no done pulse; a write not yet accepted is not completed.

Configuration
REQ-027 SHALL: macro DM_STORE_MISALIGN_CHECK_EN.
- Defined: SH with addr[0]=1, or SW with addr[1:0]!=0, goes IDLE->DONE with err=1 and no access.
- Undefined: SH ignores addr[0], SW ignores addr[1:0]; err only per REQ-022.

Structure
REQ-028 SHALL: the shared package holds the store opcode constants and the FSM state encoding.
REQ-029 SHALL: lane merging lives in one combinational sub-module st_merge (op, addr[1:0], old word, wdata -> merged word).

Verification
REQ-030 SHALL: SW, addr=0x0000_0010, wdata=0xDEAD_BEEF, mem_ready=1 -> mem_wr at cycle+1 to 0x10 with 0xDEAD_BEEF; done at cycle+2; err=0.
REQ-031 SHALL: SB, addr=0x13, wdata=0x0000_00AB, read returns 0x1122_3344 -> write 0xAB22_3344 to 0x10; done at cycle+4.
REQ-032 SHALL: SH, addr=0x12, wdata=0x0000_CAFE, read 0x1122_3344, mem_ready low 3 cycles in READ and 2 in WRITE -> write 0xCAFE_3344; mem_rd/mem_wr held; done 5 cycles late.
REQ-033 SHALL: SW addr=0x12 -> with the macro: done+err, no mem_wr; without the macro: write to 0x10.
REQ-034 SHALL: assert rst while in WRITE with mem_ready=0 -> mem_wr drops asynchronously; no done; a following SW completes normally.
REQ-035 SHALL: op=6'b100011 (LW) -> done with err=1 after 1 cycle; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/dm_store_unit_pkg.sv
// Shared definitions for the store unit: MIPS store opcodes, FSM state encoding
// and opcode classification helpers.
package dm_store_unit_pkg;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] addr_lo);
    return ((op == OP_SH) && addr_lo[0]) || ((op == OP_SW) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dm_store_unit_if.sv
// Request/response and word-memory bus of the store unit.
// slave = the store unit, master = requester plus memory side.
interface dm_store_unit_if;
  logic        start;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  start, op, addr, wdata, mem_rdata, mem_ready,
    output busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output start, op, addr, wdata, mem_rdata, mem_ready,
    input  busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/dm_store_unit_st_merge.sv
// Byte-lane merge for sub-word stores: overlays the store data onto the word read
// from memory. SH looks only at addr[1]; SW replaces every lane.
module st_merge
  import dm_store_unit_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       sel;
      logic [7:0] src;

      always_comb begin
        sel = 1'b0;
        src = wdata_i[8*gi +: 8];
        if (op_i == OP_SB) begin
          sel = (addr_lo_i == LANE);
          src = wdata_i[7:0];
        end else if (op_i == OP_SH) begin
          sel = (addr_lo_i[1] == LANE[1]);
          src = wdata_i[8*(gi%2) +: 8];
        end else if (op_i == OP_SW) begin
          sel = 1'b1;
        end
      end

      assign merged_o[8*gi +: 8] = sel ? src : old_i[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/dm_store_unit.sv
// Store unit turning SB/SH/SW into word-only memory traffic (read-modify-write
// for sub-word stores). Define DM_STORE_MISALIGN_CHECK_EN to reject misaligned SH/SW.
module dm_store_unit
  import dm_store_unit_pkg::*;
(
  input logic              clk,
  input logic              rst,
  dm_store_unit_if.slave   bus
);

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        err_q, err_d;
  logic [31:0] merged;
  logic        reject;

  st_merge u_merge (
    .op_i      (op_q),
    .addr_lo_i (addr_q[1:0]),
    .old_i     (rdata_q),
    .wdata_i   (wdata_q),
    .merged_o  (merged)
  );

  always_comb begin
    reject = !is_store(bus.op);
`ifdef DM_STORE_MISALIGN_CHECK_EN
    reject = reject | is_misaligned(bus.op, bus.addr[1:0]);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          err_d   = reject;
          if (reject) begin
            state_d = ST_DONE;
          end else if (bus.op == OP_SW) begin
            // Full word needs no read; load the write data directly.
            mem_wdata_d = bus.wdata;
            state_d     = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (bus.mem_ready) begin
          rdata_d = bus.mem_rdata;
          state_d = ST_MERGE;
        end
      end
      ST_MERGE: begin
        mem_wdata_d = merged;
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.mem_ready) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = (state_q == ST_DONE) & err_q;
  assign bus.mem_rd    = (state_q == ST_READ);
  assign bus.mem_wr    = (state_q == ST_WRITE);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = mem_wdata_q;

endmodule
